// File: rtl/hazard_forward_unit.sv
// Purpose : EX operand forwarding, load-use stall sequencing and data-memory freeze for the 5-stage pipeline.
// Latency : forwardA/B, freeze and RUN-state stall/bubble are combinational (same cycle); load-use stall lasts LOAD_LAT non-frozen cycles.
// Backpressure: freeze holds every pipeline register while a load waits on mem_ready; stall/bubble are forced low while frozen.
//
// Ports:
//   clk, rst_n                         pipeline clock, asynchronous active-low reset
//   rs_num_ID, rt_num_ID               source registers of the instruction in ID
//   rs_num_EX, rt_num_EX, rd_num_EX    sources / destination held in ID/EX
//   wr_enable_EX, mem_read_EX          ID/EX register-write and load flags
//   rd_num_MEM, wr_enable_MEM          EX/MEM destination and write flag
//   rd_num_WB, wr_enable_WB            MEM/WB destination and write flag
//   mem_read_MEM, mem_ready            load in MEM, data memory has returned data
//   flush                              taken branch squashing IF/ID this cycle
//   forwardA, forwardB                 operand select: 0 regfile, 1 WB data, 2 MEM ALU result
//   stall, bubble, freeze              PC/IF-ID hold, ID/EX bubble, global pipeline hold
//   stall_cycles                       saturating count of cycles with stall or freeze

module hazard_forward_unit #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs_num_ID,
    input  logic [REG_AW-1:0] rt_num_ID,
    input  logic [REG_AW-1:0] rs_num_EX,
    input  logic [REG_AW-1:0] rt_num_EX,
    input  logic [REG_AW-1:0] rd_num_EX,
    input  logic              wr_enable_EX,
    input  logic              mem_read_EX,
    input  logic [REG_AW-1:0] rd_num_MEM,
    input  logic [REG_AW-1:0] rd_num_WB,
    input  logic              wr_enable_MEM,
    input  logic              wr_enable_WB,
    input  logic              mem_read_MEM,
    input  logic              mem_ready,
    input  logic              flush,
    output logic [1:0]        forwardA,
    output logic [1:0]        forwardB,
    output logic              stall,
    output logic              bubble,
    output logic              freeze,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [0:0] ST_RUN        = 1'b0;
    localparam logic [0:0] ST_LOAD_STALL = 1'b1;

    // Remaining stall cycles after the detection cycle itself.
    localparam logic [3:0] LAT_M1 = 4'(LOAD_LAT - 1);

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_WB  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    logic [0:0]       state_q, state_nxt;
    logic [3:0]       cnt_q, cnt_nxt;
    logic [CNT_W-1:0] stall_cycles_q;
    logic             freeze_i;
    logic             load_use;
    logic             stall_i;
    logic             cnt_sat;

    // Register 0 is hard-wired zero when ZERO_REG is set, so it never
    // produces a value worth forwarding or waiting for.
    function automatic logic src_ok(input logic [REG_AW-1:0] r);
        return (ZERO_REG == 0) || (r != '0);
    endfunction

    // MEM is checked first: it holds the younger result for the same register.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
        logic [1:0] sel;
        sel = FWD_RF;
        if (wr_enable_MEM && (rd_num_MEM == src) && src_ok(src)) begin
            sel = FWD_MEM;
        end else if (wr_enable_WB && (rd_num_WB == src) && src_ok(src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    // ------------------------------------------------------------------
    // Combinational forwarding, freeze and hazard detection
    // ------------------------------------------------------------------
    always_comb begin
        forwardA = fwd_sel(rs_num_EX);
        forwardB = fwd_sel(rt_num_EX);
    end

    // Gated by rst_n so the pipeline is not held while the core is in reset.
    assign freeze_i = rst_n & mem_read_MEM & ~mem_ready;

    // flush squashes the dependent instruction, so there is nothing to stall
    // for; a frozen cycle makes no forward progress and cannot start a stall.
    assign load_use = mem_read_EX & wr_enable_EX & src_ok(rd_num_EX)
                    & ((rd_num_EX == rs_num_ID) | (rd_num_EX == rt_num_ID))
                    & ~flush & ~freeze_i;

    // ------------------------------------------------------------------
    // Stall FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        stall_i   = 1'b0;
        // While frozen everything holds and flush is ignored.
        if (!freeze_i) begin
            case (state_q)
                ST_RUN: begin
                    stall_i = load_use;
                    if (load_use && (LOAD_LAT > 1)) begin
                        state_nxt = ST_LOAD_STALL;
                        cnt_nxt   = LAT_M1;
                    end
                end
                ST_LOAD_STALL: begin
                    if (flush) begin
                        state_nxt = ST_RUN;
                        cnt_nxt   = 4'd0;
                    end else begin
                        stall_i = 1'b1;
                        if (cnt_q == 4'd1) begin
                            state_nxt = ST_RUN;
                            cnt_nxt   = 4'd0;
                        end else begin
                            cnt_nxt = cnt_q - 4'd1;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    // Outputs drop the moment reset asserts, without waiting for a clock.
    assign stall  = stall_i & rst_n;
    assign bubble = stall_i & rst_n;
    assign freeze = freeze_i;

    // ------------------------------------------------------------------
    // Saturating stall/freeze statistics
    // ------------------------------------------------------------------
    assign cnt_sat = &stall_cycles_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
        end else if ((stall_i | freeze_i) && !cnt_sat) begin
            stall_cycles_q <= stall_cycles_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Purpose : scoreboard bench for hazard_forward_unit across three parameter sets sharing one stimulus.
// Latency : expectations are pushed in the cycle the stimulus is applied and checked on the following falling edge.
// Backpressure: none; the monitor drains the whole expectation queue on every falling edge.

module tb_hazard_forward_unit;

    logic       clk;
    logic       rst_n;
    logic [4:0] rs_num_ID, rt_num_ID, rs_num_EX, rt_num_EX, rd_num_EX;
    logic       wr_enable_EX, mem_read_EX;
    logic [4:0] rd_num_MEM, rd_num_WB;
    logic       wr_enable_MEM, wr_enable_WB, mem_read_MEM, mem_ready, flush;

    logic [1:0]  fa_a, fb_a, fa_b, fb_b, fa_c, fb_c;
    logic        stall_a, bubble_a, freeze_a;
    logic        stall_b, bubble_b, freeze_b;
    logic        stall_c, bubble_c, freeze_c;
    logic [15:0] sc_a, sc_b;
    logic [3:0]  sc_c;

    // a: defaults; b: ZERO_REG=0, LOAD_LAT=3; c: LOAD_LAT=2, CNT_W=4
    hazard_forward_unit u_a (
        .clk(clk), .rst_n(rst_n), .rs_num_ID(rs_num_ID), .rt_num_ID(rt_num_ID),
        .rs_num_EX(rs_num_EX), .rt_num_EX(rt_num_EX), .rd_num_EX(rd_num_EX),
        .wr_enable_EX(wr_enable_EX), .mem_read_EX(mem_read_EX),
        .rd_num_MEM(rd_num_MEM), .rd_num_WB(rd_num_WB),
        .wr_enable_MEM(wr_enable_MEM), .wr_enable_WB(wr_enable_WB),
        .mem_read_MEM(mem_read_MEM), .mem_ready(mem_ready), .flush(flush),
        .forwardA(fa_a), .forwardB(fb_a), .stall(stall_a), .bubble(bubble_a),
        .freeze(freeze_a), .stall_cycles(sc_a)
    );

    hazard_forward_unit #(.LOAD_LAT(3), .ZERO_REG(0)) u_b (
        .clk(clk), .rst_n(rst_n), .rs_num_ID(rs_num_ID), .rt_num_ID(rt_num_ID),
        .rs_num_EX(rs_num_EX), .rt_num_EX(rt_num_EX), .rd_num_EX(rd_num_EX),
        .wr_enable_EX(wr_enable_EX), .mem_read_EX(mem_read_EX),
        .rd_num_MEM(rd_num_MEM), .rd_num_WB(rd_num_WB),
        .wr_enable_MEM(wr_enable_MEM), .wr_enable_WB(wr_enable_WB),
        .mem_read_MEM(mem_read_MEM), .mem_ready(mem_ready), .flush(flush),
        .forwardA(fa_b), .forwardB(fb_b), .stall(stall_b), .bubble(bubble_b),
        .freeze(freeze_b), .stall_cycles(sc_b)
    );

    hazard_forward_unit #(.LOAD_LAT(2), .CNT_W(4)) u_c (
        .clk(clk), .rst_n(rst_n), .rs_num_ID(rs_num_ID), .rt_num_ID(rt_num_ID),
        .rs_num_EX(rs_num_EX), .rt_num_EX(rt_num_EX), .rd_num_EX(rd_num_EX),
        .wr_enable_EX(wr_enable_EX), .mem_read_EX(mem_read_EX),
        .rd_num_MEM(rd_num_MEM), .rd_num_WB(rd_num_WB),
        .wr_enable_MEM(wr_enable_MEM), .wr_enable_WB(wr_enable_WB),
        .mem_read_MEM(mem_read_MEM), .mem_ready(mem_ready), .flush(flush),
        .forwardA(fa_c), .forwardB(fb_c), .stall(stall_c), .bubble(bubble_c),
        .freeze(freeze_c), .stall_cycles(sc_c)
    );

    localparam int S_FA_A = 0,  S_FB_A = 1,  S_ST_A = 2,  S_BU_A = 3,  S_FZ_A = 4;
    localparam int S_SC_A = 5,  S_FA_B = 6,  S_FB_B = 7,  S_ST_B = 8,  S_BU_B = 9;
    localparam int S_SC_B = 10, S_ST_C = 11, S_BU_C = 12, S_FZ_C = 13, S_SC_C = 14;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            S_FA_A:  return 32'(fa_a);
            S_FB_A:  return 32'(fb_a);
            S_ST_A:  return 32'(stall_a);
            S_BU_A:  return 32'(bubble_a);
            S_FZ_A:  return 32'(freeze_a);
            S_SC_A:  return 32'(sc_a);
            S_FA_B:  return 32'(fa_b);
            S_FB_B:  return 32'(fb_b);
            S_ST_B:  return 32'(stall_b);
            S_BU_B:  return 32'(bubble_b);
            S_SC_B:  return 32'(sc_b);
            S_ST_C:  return 32'(stall_c);
            S_BU_C:  return 32'(bubble_c);
            S_FZ_C:  return 32'(freeze_c);
            S_SC_C:  return 32'(sc_c);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_val(input string name, input int sel, input int exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = 32'(exp);
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs_num_ID = '0; rt_num_ID = '0; rs_num_EX = '0; rt_num_EX = '0; rd_num_EX = '0;
        wr_enable_EX = 1'b0; mem_read_EX = 1'b0;
        rd_num_MEM = '0; rd_num_WB = '0;
        wr_enable_MEM = 1'b0; wr_enable_WB = 1'b0;
        mem_read_MEM = 1'b0; mem_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic set_load_use();
        mem_read_EX  = 1'b1;
        wr_enable_EX = 1'b1;
        rd_num_EX    = 5'd5;
        rt_num_ID    = 5'd5;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: outputs are presented every cycle; check all pending entries on the falling edge.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e   = sb.pop_front();
                act = actual(e.sel);
                n_cmp++;
                if (act !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %0d expected %0d", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state: forwarding stays live, stall/freeze/counter forced low.
        rst_n = 1'b0;
        clear_inputs();
        rs_num_EX = 5'd3; rd_num_MEM = 5'd3; wr_enable_MEM = 1'b1;
        mem_read_MEM = 1'b1; mem_ready = 1'b0;
        set_load_use();
        expect_val("rst_fwdA",   S_FA_A, 2);
        expect_val("rst_stall",  S_ST_A, 0);
        expect_val("rst_bubble", S_BU_A, 0);
        expect_val("rst_freeze", S_FZ_A, 0);
        expect_val("rst_cnt_a",  S_SC_A, 0);
        expect_val("rst_cnt_c",  S_SC_C, 0);

        // Forwarding priority
        cyc();
        clear_inputs();
        rst_n = 1'b1;
        rs_num_EX = 5'd3; rt_num_EX = 5'd3; rd_num_MEM = 5'd3; rd_num_WB = 5'd3;
        wr_enable_MEM = 1'b1; wr_enable_WB = 1'b1;
        expect_val("fwd_both_A", S_FA_A, 2);
        expect_val("fwd_both_B", S_FB_A, 2);
        cyc();
        wr_enable_MEM = 1'b0;
        expect_val("fwd_wb_A", S_FA_A, 1);
        expect_val("fwd_wb_B", S_FB_A, 1);
        cyc();
        rs_num_EX = 5'd7; rt_num_EX = 5'd3;
        expect_val("fwd_none_A", S_FA_A, 0);
        expect_val("fwd_wb_B2",  S_FB_A, 1);

        // R0 guard
        cyc();
        clear_inputs();
        rd_num_MEM = 5'd0; rs_num_EX = 5'd0; wr_enable_MEM = 1'b1;
        expect_val("r0_guard_on",  S_FA_A, 0);
        expect_val("r0_guard_off", S_FA_B, 2);

        // Load-use, LOAD_LAT = 3 (instance b)
        cyc();
        do_reset();
        set_load_use();
        expect_val("lu3_c1_stall",  S_ST_B, 1);
        expect_val("lu3_c1_bubble", S_BU_B, 1);
        cyc();
        expect_val("lu3_c2_stall", S_ST_B, 1);
        cyc();
        expect_val("lu3_c3_stall",  S_ST_B, 1);
        expect_val("lu3_c3_bubble", S_BU_B, 1);
        cyc();
        mem_read_EX = 1'b0;
        expect_val("lu3_c4_stall", S_ST_B, 0);
        expect_val("lu3_count",    S_SC_B, 3);
        cyc();
        expect_val("lu3_count_hold", S_SC_B, 3);

        // Freeze mid-stall, LOAD_LAT = 2 (instance c)
        cyc();
        do_reset();
        set_load_use();
        expect_val("fz_detect_stall", S_ST_C, 1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            mem_read_MEM = 1'b1; mem_ready = 1'b0;
            expect_val("fz_freeze", S_FZ_C, 1);
            expect_val("fz_stall0", S_ST_C, 0);
            expect_val("fz_bubble0", S_BU_C, 0);
        end
        cyc();
        mem_read_MEM = 1'b0;
        expect_val("fz_resume_stall",  S_ST_C, 1);
        expect_val("fz_resume_freeze", S_FZ_C, 0);
        cyc();
        mem_read_EX = 1'b0;
        mem_read_MEM = 1'b1; mem_ready = 1'b1;
        expect_val("fz_done_stall", S_ST_C, 0);
        expect_val("fz_ready_nofz", S_FZ_C, 0);
        expect_val("fz_count",      S_SC_C, 6);

        // Flush
        cyc();
        do_reset();
        set_load_use();
        flush = 1'b1;
        expect_val("fl_same_b", S_ST_B, 0);
        expect_val("fl_same_c", S_BU_C, 0);
        cyc();
        flush = 1'b0;
        expect_val("fl_start_stall", S_ST_B, 1);
        cyc();
        flush = 1'b1;
        expect_val("fl_mid_stall",  S_ST_B, 0);
        expect_val("fl_mid_bubble", S_BU_B, 0);
        cyc();
        flush = 1'b0; mem_read_EX = 1'b0;
        expect_val("fl_back_run", S_ST_B, 0);
        expect_val("fl_count",    S_SC_B, 1);

        // Saturation: 20 freeze cycles
        cyc();
        do_reset();
        mem_read_MEM = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 20; i++) cyc();
        expect_val("sat_cnt4",  S_SC_C, 15);
        expect_val("sat_cnt16", S_SC_B, 20);

        // Reset asserted mid-stall
        cyc();
        do_reset();
        set_load_use();
        expect_val("rs_c1_stall", S_ST_B, 1);
        cyc();
        expect_val("rs_c2_stall", S_ST_B, 1);
        expect_val("rs_c2_count", S_SC_B, 1);
        cyc();
        rst_n = 1'b0;
        expect_val("rs_async_stall",  S_ST_B, 0);
        expect_val("rs_async_bubble", S_BU_B, 0);
        expect_val("rs_async_count",  S_SC_B, 0);
        cyc();
        rst_n = 1'b1;
        mem_read_EX = 1'b0;
        expect_val("rs_after_run",   S_ST_B, 0);
        expect_val("rs_after_count", S_SC_B, 0);

        cyc();
        cyc();
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
